// File: rtl/alu_mult_seq_pkg.sv
// Shared widths, FSM state encodings and shift-register opcodes for the
// ALU-borrowing multiply sequencer.
package alu_mult_seq_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int MULT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ITER   = 3'd1,
        DONE   = 3'd2,
        NEG_A  = 3'd3,
        NEG_B  = 3'd4,
        FIX_LO = 3'd5,
        FIX_HI = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SR_LOAD   = 2'd0,
        SR_SHIFT  = 2'd1,
        SR_WR_MQ  = 2'd2,
        SR_WR_ACC = 2'd3
    } sr_op_e;

endpackage

// File: rtl/mult_acc_sr.sv
// 33-bit {carry, acc, mq} register: loads the multiplier, shifts in each ALU
// sum, or overwrites one half (with carry capture) when negating the product.
module mult_acc_sr
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  sr_op_e           op,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mq,
    output logic             c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            mq  <= '0;
            c   <= 1'b0;
        end else if (en) begin
            case (op)
                SR_LOAD: begin
                    acc <= '0;
                    mq  <= ld_val;
                    c   <= 1'b0;
                end
                // 33-bit {cout, sum, mq} shifted right by one
                SR_SHIFT:  {acc, mq} <= {alu_cout, alu_out, mq[WIDTH-1:1]};
                SR_WR_MQ: begin
                    mq <= alu_out;
                    c  <= alu_cout;
                end
                SR_WR_ACC: acc <= alu_out;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_mult_seq.sv
// Radix-2 shift-add multiply sequencer that borrows the shared EX-stage ALU.
// Define MULT_SIGNED_EN to add two's-complement support (NEG_A/NEG_B/FIX_LO/FIX_HI).
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_signed,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] resp_prod,
    output logic               busy,
    output logic               alu_req,
    input  logic               alu_gnt,
    output logic [WIDTH-1:0]   alu_InA,
    output logic [WIDTH-1:0]   alu_InB,
    output logic               alu_Cin,
    output logic               alu_invA,
    output logic               alu_add,
    input  logic [WIDTH-1:0]   alu_Out,
    input  logic               alu_Cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mq;
    logic             sr_c;
    logic             sr_en;
    sr_op_e           sr_op;
    logic             mcand_we;
    logic             start_signed;
    logic             fix_needed;

`ifdef MULT_SIGNED_EN
    logic signed_q;
    logic sign_p_q;
    assign start_signed = req_signed;
    assign fix_needed   = signed_q & sign_p_q;
`else
    logic sig_unused;
    assign start_signed = 1'b0;
    assign fix_needed   = 1'b0;
    assign sig_unused   = ^{req_signed, sr_c};
`endif

    mult_acc_sr #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (sr_en),
        .op       (sr_op),
        .ld_val   (req_b),
        .alu_out  (alu_Out),
        .alu_cout (alu_Cout),
        .acc      (acc),
        .mq       (mq),
        .c        (sr_c)
    );

    assign busy    = (state != IDLE);
    assign alu_add = alu_req;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        alu_req   = 1'b0;
        alu_InA   = '0;
        alu_InB   = '0;
        alu_Cin   = 1'b0;
        alu_invA  = 1'b0;
        sr_en     = 1'b0;
        sr_op     = SR_LOAD;
        mcand_we  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sr_en     = 1'b1;
                    sr_op     = SR_LOAD;
                    state_nxt = start_signed ? NEG_A : ITER;
                end
            end
            ITER: begin
                alu_req = 1'b1;
                alu_InA = acc;
                alu_InB = mq[0] ? mcand : '0;
                if (alu_gnt) begin
                    sr_en = 1'b1;
                    sr_op = SR_SHIFT;
                    if (cnt == CNT_LAST)
                        state_nxt = fix_needed ? FIX_LO : DONE;
                end
            end
            DONE: begin
                if (resp_valid && resp_ready)
                    state_nxt = IDLE;
            end
`ifdef MULT_SIGNED_EN
            // Negation steps always spend a granted cycle; the write is conditional.
            NEG_A: begin
                alu_req  = 1'b1;
                alu_InA  = mcand;
                alu_invA = 1'b1;
                alu_Cin  = 1'b1;
                if (alu_gnt) begin
                    mcand_we  = mcand[WIDTH-1];
                    state_nxt = NEG_B;
                end
            end
            NEG_B: begin
                alu_req  = 1'b1;
                alu_InA  = mq;
                alu_invA = 1'b1;
                alu_Cin  = 1'b1;
                if (alu_gnt) begin
                    sr_en     = mq[WIDTH-1];
                    sr_op     = SR_WR_MQ;
                    state_nxt = ITER;
                end
            end
            FIX_LO: begin
                alu_req  = 1'b1;
                alu_InA  = mq;
                alu_invA = 1'b1;
                alu_Cin  = 1'b1;
                if (alu_gnt) begin
                    sr_en     = 1'b1;
                    sr_op     = SR_WR_MQ;
                    state_nxt = FIX_HI;
                end
            end
            FIX_HI: begin
                alu_req  = 1'b1;
                alu_InA  = acc;
                alu_invA = 1'b1;
                alu_Cin  = sr_c;
                if (alu_gnt) begin
                    sr_en     = 1'b1;
                    sr_op     = SR_WR_ACC;
                    state_nxt = DONE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mcand      <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_prod  <= '0;
`ifdef MULT_SIGNED_EN
            signed_q   <= 1'b0;
            sign_p_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                mcand <= req_a;
                cnt   <= '0;
`ifdef MULT_SIGNED_EN
                signed_q <= req_signed;
                sign_p_q <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
`endif
            end
            if (state == ITER && alu_gnt)
                cnt <= cnt + CNT_W'(1);
            if (mcand_we)
                mcand <= alu_Out;
            // First DONE cycle registers the product; it then holds until taken.
            if (state == DONE) begin
                if (!resp_valid) begin
                    resp_valid <= 1'b1;
                    resp_prod  <= {acc, mq};
                end else if (resp_ready) begin
                    resp_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural ALU behind the grant mux.
// Signed vectors are enabled when MULT_SIGNED_EN is defined.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_prod;
    logic        busy;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [15:0] alu_InA, alu_InB;
    logic        alu_Cin, alu_invA, alu_add;
    logic [15:0] alu_Out;
    logic        alu_Cout;
    logic [16:0] alu_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared ALU; without grant EX is using it for something unrelated.
    always_comb begin
        alu_sum = {1'b0, (alu_invA ? ~alu_InA : alu_InA)} + {1'b0, alu_InB} + {16'd0, alu_Cin};
    end
    assign alu_Out  = alu_gnt ? alu_sum[15:0] : 16'hDEAD;
    assign alu_Cout = alu_gnt ? alu_sum[16]   : 1'b1;

    alu_mult_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_prod  (resp_prod),
        .busy       (busy),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_InA    (alu_InA),
        .alu_InB    (alu_InB),
        .alu_Cin    (alu_Cin),
        .alu_invA   (alu_invA),
        .alu_add    (alu_add),
        .alu_Out    (alu_Out),
        .alu_Cout   (alu_Cout)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        int          stall_at;
        int          stall_len;
        int          hold;
        logic [31:0] exp_prod;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                input int stall_at, input int stall_len, input int hold,
                                input logic [31:0] exp_prod, input int exp_lat);
        vec_t v;
        v.a = a; v.b = b; v.sgn = sgn;
        v.stall_at = stall_at; v.stall_len = stall_len; v.hold = hold;
        v.exp_prod = exp_prod; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] prod;
        int lat;
        bit seen;
        req_a = v.a;
        req_b = v.b;
        req_signed = v.sgn;
        req_valid = 1'b1;
        chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            if (n == v.stall_at) alu_gnt = 1'b0;
            if (n == v.stall_at + v.stall_len) alu_gnt = 1'b1;
            if (alu_req) chk($sformatf("v%0d_alu_add", idx), {31'd0, alu_add}, 32'd1);
            @(posedge clk); #1;
            if (resp_valid) begin
                seen = 1'b1;
                lat = n;
            end
        end
        alu_gnt = 1'b1;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL v%0d_timeout: resp_valid never rose, want latency %0d", idx, v.exp_lat);
            return;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_prod", idx), resp_prod, v.exp_prod);
        prod = resp_prod;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d_hold_prod", idx), resp_prod, prod);
            chk($sformatf("v%0d_hold_valid", idx), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d_hold_ready", idx), {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d_post_valid", idx), {31'd0, resp_valid}, 32'd0);
        chk($sformatf("v%0d_post_idle", idx), {30'd0, req_ready, busy}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(16'd3,    16'd5,    1'b0, 0, 0, 0, 32'h0000000F, 17));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 0, 32'hFFFE0001, 17));
        vecs.push_back(mk(16'h1234, 16'h0000, 1'b0, 0, 0, 0, 32'h00000000, 17));
        vecs.push_back(mk(16'h0000, 16'hFFFF, 1'b0, 0, 0, 0, 32'h00000000, 17));
        vecs.push_back(mk(16'h00FF, 16'h0101, 1'b0, 5, 3, 0, 32'h0000FFFF, 20));
        vecs.push_back(mk(16'hABCD, 16'h0002, 1'b0, 0, 0, 5, 32'h0001579A, 17));
        vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 0, 0, 0, 32'h40000000, 17));
`ifdef MULT_SIGNED_EN
        vecs.push_back(mk(16'hFFFD, 16'd5,    1'b1, 0, 0, 0, 32'hFFFFFFF1, 21));
        vecs.push_back(mk(16'h8000, 16'h8000, 1'b1, 0, 0, 0, 32'h40000000, 19));
        vecs.push_back(mk(16'd7,    16'd9,    1'b1, 0, 0, 0, 32'h0000003F, 19));
        vecs.push_back(mk(16'd5,    16'hFFFD, 1'b1, 4, 2, 0, 32'hFFFFFFF1, 23));
`else
        vecs.push_back(mk(16'hFFFD, 16'd5,    1'b1, 0, 0, 0, 32'h0004FFF1, 17));
        vecs.push_back(mk(16'd7,    16'd9,    1'b1, 0, 0, 0, 32'h0000003F, 17));
`endif

        #3;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_alu_req",    {31'd0, alu_req},    32'd0);
        chk("rst_resp_prod",  resp_prod,           32'd0);
        chk("rst_alu_drives", {12'd0, alu_InA, alu_Cin, alu_invA, alu_add, 1'b0}, 32'd0);
        chk("rst_alu_inb",    {16'd0, alu_InB},    32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(i, vecs[i]);

        // Abort mid-iteration: cnt reaches 7 after the 7th granted edge.
        req_a = 16'h1111;
        req_b = 16'h2222;
        req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 7; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",       {31'd0, busy},       32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_req_ready",  {31'd0, req_ready},  32'd1);
        chk("abort_resp_prod",  resp_prod,           32'd0);
        chk("abort_alu_req",    {31'd0, alu_req},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(100, mk(16'd7, 16'd9, 1'b0, 0, 0, 0, 32'h0000003F, 17));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
